// File: rtl/ltc2308_sampler.sv
// LTC2308 SPI ADC sampler: fixed-rate CONVST/SCK sequencing, 6-bit config write-out and 12-bit
// readback, with channel tagging that follows the ADC's one-frame config pipeline.
module ltc2308_sampler #(
    parameter int unsigned SAMPLE_DIV    = 1000,
    parameter int unsigned CONVST_CYCLES = 2,
    parameter int unsigned CONV_CYCLES   = 80,
    parameter int unsigned SCK_HALF      = 2,
    parameter int unsigned UNIPOLAR      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [2:0]  channel,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic [11:0] adc_data,
    output logic [2:0]  adc_channel,
    output logic        sample_strobe,
    output logic        busy
);

    localparam int unsigned FCNT_W = $clog2(SAMPLE_DIV);
    localparam int unsigned HCNT_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int unsigned T0     = CONVST_CYCLES + CONV_CYCLES;

    if (SAMPLE_DIV < CONVST_CYCLES + CONV_CYCLES + 24 * SCK_HALF + 2 ||
        CONVST_CYCLES == 0 || CONV_CYCLES == 0 || SCK_HALF == 0) begin : g_param_check
        $error("ltc2308_sampler: SAMPLE_DIV too small for the configured frame timing");
    end

    typedef enum logic [2:0] {StIdle, StConvst, StConvWait, StShift, StDone} state_t;

    state_t              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic                sck_hi_q, sck_hi_d;
    logic [3:0]          bit_q, bit_d;
    logic [11:0]         shreg_q;
    logic [5:0]          sdi_sr_q;
    logic [2:0]          cfg_ch_q, prev_ch_q;
    logic                suppress_q;
    logic                latch_cfg, capture, frame_end;

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q + FCNT_W'(1);
        hcnt_d    = hcnt_q;
        sck_hi_d  = sck_hi_q;
        bit_d     = bit_q;
        latch_cfg = 1'b0;
        capture   = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                // fcnt==0 here means a held (stopped) idle; otherwise wait out the frame period.
                fcnt_d = '0;
                if (run) begin
                    if (fcnt_q == '0 || fcnt_q == FCNT_W'(SAMPLE_DIV - 1)) begin
                        state_d   = StConvst;
                        latch_cfg = 1'b1;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
            end
            StConvst: begin
                if (fcnt_q == FCNT_W'(CONVST_CYCLES - 1)) state_d = StConvWait;
            end
            StConvWait: begin
                hcnt_d   = '0;
                sck_hi_d = 1'b0;
                bit_d    = '0;
                if (fcnt_q == FCNT_W'(T0 - 1)) state_d = StShift;
            end
            StShift: begin
                if (hcnt_q == HCNT_W'(SCK_HALF - 1)) begin
                    hcnt_d = '0;
                    if (!sck_hi_q) begin
                        sck_hi_d = 1'b1;
                        capture  = 1'b1;
                    end else begin
                        sck_hi_d = 1'b0;
                        bit_d    = bit_q + 4'd1;
                        if (bit_q == 4'd11) begin
                            bit_d     = '0;
                            state_d   = StDone;
                            frame_end = 1'b1;
                        end
                    end
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            fcnt_q        <= '0;
            hcnt_q        <= '0;
            sck_hi_q      <= 1'b0;
            bit_q         <= '0;
            shreg_q       <= '0;
            sdi_sr_q      <= '0;
            cfg_ch_q      <= '0;
            prev_ch_q     <= '0;
            suppress_q    <= 1'b1;
            adc_data      <= '0;
            adc_channel   <= '0;
            sample_strobe <= 1'b0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            hcnt_q        <= hcnt_d;
            sck_hi_q      <= sck_hi_d;
            bit_q         <= bit_d;
            sample_strobe <= frame_end && !suppress_q;
            if (latch_cfg) begin
                cfg_ch_q <= channel;
                sdi_sr_q <= {1'b1, channel[0], channel[2], channel[1], UNIPOLAR != 0, 1'b0};
            end
            // Advance the config bit only as a new low phase begins.
            if (state_q == StShift && sck_hi_q && hcnt_q == HCNT_W'(SCK_HALF - 1)) begin
                sdi_sr_q <= {sdi_sr_q[4:0], 1'b0};
            end
            if (capture) shreg_q <= {shreg_q[10:0], adc_sdo};
            if (frame_end) begin
                adc_data    <= shreg_q;
                adc_channel <= prev_ch_q;
                prev_ch_q   <= cfg_ch_q;
                suppress_q  <= 1'b0;
            end
        end
    end

    assign adc_convst = (state_q == StConvst);
    assign adc_sck    = (state_q == StShift) && sck_hi_q;
    assign adc_sdi    = (state_q == StShift) && sdi_sr_q[5];
    assign busy       = (state_q != StIdle);

endmodule
